router_reg: RTL and testbench
=============================

Name: router_reg

Overview:
Datapath register stage of the 1x3 router, directly downstream of router_fsm. Uses the FSM state strobes to latch the header byte, pass payload bytes to the FIFO write bus, and hold the one byte blocked by a full FIFO. Accumulates byte-wise XOR parity and checks it against the trailing parity byte. Returns parity_done and low_packet_valid to the FSM.

Parameters:
DATA_WIDTH, 8, byte width of data_in/dout
ADDR_WIDTH, 2, header address field width, header[ADDR_WIDTH-1:0]
INVALID_ADDR, 2'b11, address value that is never latched as a header

Ports:
clock  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
pkt_valid  in  1  source asserts for header+payload, deasserts with the parity byte
data_in  in  DATA_WIDTH  source byte
fifo_full  in  1  selected FIFO full
detect_add  in  1  FSM state DECODE_ADDRESS
lfd_state  in  1  FSM state LOAD_FIRST_DATA
ld_state  in  1  FSM state LOAD_DATA
laf_state  in  1  FSM state LOAD_AFTER_FULL
full_state  in  1  FSM state FIFO_FULL_STATE
rst_int_reg  in  1  FSM state CHECK_PARITY_ERROR; clears low_packet_valid
parity_done  out  1  parity byte captured
low_packet_valid  out  1  pkt_valid fell while in LOAD_DATA
err  out  1  parity mismatch
dout  out  DATA_WIDTH  byte to the FIFO write bus

Behaviour:
- Reset (resetn=0, async): dout, err, parity_done, low_packet_valid, header, hold_byte, int_parity and pkt_parity are all cleared to 0 at once. Reset mid-packet abandons the packet.
- Header latch: detect_add && pkt_valid && data_in[ADDR_WIDTH-1:0]!=INVALID_ADDR -> header<=data_in on the next edge.
- dout priority, first match wins:
  1. lfd_state -> header
  2. ld_state && !fifo_full -> data_in
  3. ld_state && fifo_full -> hold_byte<=data_in; dout unchanged
  4. laf_state -> hold_byte
  5. otherwise dout holds
- Latency: 1 cycle from qualifying state to dout.
- int_parity:
  - cleared on detect_add
  - lfd_state -> ^=header
  - ld_state && pkt_valid && !full_state -> ^=data_in
  - all other states hold
- pkt_parity: ld_state && !pkt_valid -> pkt_parity<=data_in.
- low_packet_valid: set on ld_state && !pkt_valid; cleared on rst_int_reg. If both occur in one cycle, clear wins.
- parity_done:
  - cleared on detect_add
  - set on (ld_state && !fifo_full && !pkt_valid) or (laf_state && low_packet_valid && !parity_done)
  - sticky until the next detect_add
- err:
  - cleared on detect_add
  - when parity_done=1, err<=(int_parity!=pkt_parity), valid one cycle after parity_done rises
  - held until the next detect_add
- Simultaneous detect_add and parity_done: detect_add wins.
- Invalid-address header (addr 3): header is not updated; the previous value stays.

Optional Feature:
ROUTER_REG_PARITY_CHK_EN
- Defined: int_parity/pkt_parity compare drives err as above.
- Undefined: parity logic is removed and err is tied 0. parity_done and low_packet_valid are unchanged, so the FSM flow is identical.

Decomposition:
- Package router_pkg: DATA_WIDTH, ADDR_WIDTH, INVALID_ADDR, and the FSM state encoding, shared with router_fsm, router_fifo and router_sync.
- Sub-module router_parity_acc: owns int_parity, pkt_parity and err. Inputs are the clear and accumulate strobes. Instantiated only under ROUTER_REG_PARITY_CHK_EN.

Test Plan:
1. Good packet: header 8'h0C, payload 8'h11, 8'h22, 8'h33, parity 8'h0C with pkt_valid low. Expect dout sequence 0C, 11, 22, 33; parity_done=1; err=0 one cycle later.
2. Bad parity: same packet with parity 8'h0D. Expect err=1 one cycle after parity_done, held until the next detect_add.
3. FIFO full mid-payload: fifo_full=1 in ld_state with data_in=8'h22, then full_state, then laf_state. Expect dout held at 8'h11, then 8'h22 in laf_state. Final err=0 with parity 8'h0C.
4. Late pkt_valid drop under full: pkt_valid falls while fifo_full=1. Expect low_packet_valid=1, and parity_done rising in laf_state. rst_int_reg then clears low_packet_valid.
5. Invalid address: detect_add with data_in=8'h0F (addr 3). Expect header unchanged; lfd_state outputs the previous header.
6. Reset mid-payload: resetn=0 after byte 8'h11. Expect every output 0 immediately, without waiting for a clock edge. The next packet 8'h0C... passes with err=0.

Source files
------------

// File: rtl/router_pkg.sv
// Shared router constants and FSM state encoding used by router_fsm, router_reg,
// router_fifo and router_sync.
package router_pkg;
    localparam int DATA_WIDTH = 8;
    localparam int ADDR_WIDTH = 2;
    localparam logic [ADDR_WIDTH-1:0] INVALID_ADDR = 2'b11;

    typedef logic [DATA_WIDTH-1:0] byte_t;

    typedef enum logic [2:0] {
        DECODE_ADDRESS,
        LOAD_FIRST_DATA,
        LOAD_DATA,
        LOAD_PARITY,
        FIFO_FULL_STATE,
        LOAD_AFTER_FULL,
        WAIT_TILL_EMPTY,
        CHECK_PARITY_ERROR
    } fsm_state_e;

    // Address 3 has no output port, so such a header is never latched.
    function automatic logic addr_ok(input byte_t b);
        return b[ADDR_WIDTH-1:0] != INVALID_ADDR;
    endfunction
endpackage

// File: rtl/router_reg_if.sv
// Bundle between router_fsm/source (master) and the router_reg datapath stage (slave).
interface router_reg_if;
    import router_pkg::*;

    logic  pkt_valid;
    byte_t data_in;
    logic  fifo_full;
    logic  detect_add;
    logic  lfd_state;
    logic  ld_state;
    logic  laf_state;
    logic  full_state;
    logic  rst_int_reg;
    logic  parity_done;
    logic  low_packet_valid;
    logic  err;
    byte_t dout;

    modport master (
        output pkt_valid, data_in, fifo_full, detect_add, lfd_state, ld_state,
               laf_state, full_state, rst_int_reg,
        input  parity_done, low_packet_valid, err, dout
    );

    modport slave (
        input  pkt_valid, data_in, fifo_full, detect_add, lfd_state, ld_state,
               laf_state, full_state, rst_int_reg,
        output parity_done, low_packet_valid, err, dout
    );
endinterface

// File: rtl/router_parity_acc.sv
// Running XOR parity of header+payload, captured trailing parity byte, and the
// mismatch flag evaluated once parity_done is up.
module router_parity_acc
    import router_pkg::*;
(
    input  logic  clock,
    input  logic  resetn,
    input  logic  clr,
    input  logic  acc_en,
    input  byte_t acc_byte,
    input  logic  cap_en,
    input  byte_t cap_byte,
    input  logic  chk_en,
    output logic  err
);
    byte_t int_parity;
    byte_t pkt_parity;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            int_parity <= '0;
            pkt_parity <= '0;
            err        <= 1'b0;
        end else begin
            if (clr)
                int_parity <= '0;
            else if (acc_en)
                int_parity <= int_parity ^ acc_byte;

            if (cap_en)
                pkt_parity <= cap_byte;

            // A new packet's decode overrides a pending compare.
            if (clr)
                err <= 1'b0;
            else if (chk_en)
                err <= (int_parity != pkt_parity);
        end
    end
endmodule

// File: rtl/router_reg.sv
// Router datapath register stage: header latch, FIFO write byte, full-hold byte,
// parity handshake. Parity checking is built only with ROUTER_REG_PARITY_CHK_EN.
module router_reg
    import router_pkg::*;
(
    input  logic         clock,
    input  logic         resetn,
    router_reg_if.slave  bus
);
    byte_t header;
    byte_t hold_byte;
    byte_t dout_q;
    logic  pd_q;
    logic  lpv_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            header    <= '0;
            hold_byte <= '0;
            dout_q    <= '0;
            pd_q      <= 1'b0;
            lpv_q     <= 1'b0;
        end else begin
            if (bus.detect_add && bus.pkt_valid && addr_ok(bus.data_in))
                header <= bus.data_in;

            // A byte arriving while the FIFO is full is parked and replayed in LOAD_AFTER_FULL.
            if (bus.lfd_state)
                dout_q <= header;
            else if (bus.ld_state && !bus.fifo_full)
                dout_q <= bus.data_in;
            else if (bus.ld_state)
                hold_byte <= bus.data_in;
            else if (bus.laf_state)
                dout_q <= hold_byte;

            if (bus.rst_int_reg)
                lpv_q <= 1'b0;
            else if (bus.ld_state && !bus.pkt_valid)
                lpv_q <= 1'b1;

            if (bus.detect_add)
                pd_q <= 1'b0;
            else if ((bus.ld_state && !bus.fifo_full && !bus.pkt_valid) ||
                     (bus.laf_state && lpv_q && !pd_q))
                pd_q <= 1'b1;
        end
    end

    assign bus.dout             = dout_q;
    assign bus.parity_done      = pd_q;
    assign bus.low_packet_valid = lpv_q;

`ifdef ROUTER_REG_PARITY_CHK_EN
    router_parity_acc u_par (
        .clock    (clock),
        .resetn   (resetn),
        .clr      (bus.detect_add),
        .acc_en   (bus.lfd_state || (bus.ld_state && bus.pkt_valid && !bus.full_state)),
        .acc_byte (bus.lfd_state ? header : bus.data_in),
        .cap_en   (bus.ld_state && !bus.pkt_valid),
        .cap_byte (bus.data_in),
        .chk_en   (pd_q),
        .err      (bus.err)
    );
`else
    logic unused_full;
    assign unused_full = bus.full_state;
    assign bus.err     = 1'b0;
`endif
endmodule

// File: tb/tb_router_reg.sv
// Directed cycle-by-cycle vectors for router_reg plus hand sequences for
// clear-vs-set priority and asynchronous reset mid-packet.
module tb_router_reg;
    import router_pkg::*;

`ifdef ROUTER_REG_PARITY_CHK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic clock;
    logic resetn;
    int   n_run  = 0;
    int   n_fail = 0;

    router_reg_if bus ();
    router_reg dut (.clock(clock), .resetn(resetn), .bus(bus.slave));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        fsm_state_e st;
        logic       pv;
        logic       ff;
        byte_t      din;
        byte_t      dout;
        logic       pd;
        logic       lpv;
        logic       err;
    } vec_t;

    vec_t vq[$];

    task automatic add(input fsm_state_e st, input logic pv, input logic ff, input byte_t din,
                       input byte_t d, input logic pd, input logic lpv, input logic e);
        vec_t v;
        v = '{st, pv, ff, din, d, pd, lpv, e};
        vq.push_back(v);
    endtask

    task automatic drive(input fsm_state_e st, input logic pv, input logic ff,
                         input byte_t din, input logic extra_rst);
        bus.pkt_valid   = pv;
        bus.fifo_full   = ff;
        bus.data_in     = din;
        bus.detect_add  = (st == DECODE_ADDRESS);
        bus.lfd_state   = (st == LOAD_FIRST_DATA);
        bus.ld_state    = (st == LOAD_DATA);
        bus.laf_state   = (st == LOAD_AFTER_FULL);
        bus.full_state  = (st == FIFO_FULL_STATE);
        bus.rst_int_reg = (st == CHECK_PARITY_ERROR) || extra_rst;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic expect4(input string tag, input byte_t d, input logic pd,
                           input logic lpv, input logic e);
        chk({tag, ".dout"}, bus.dout, d);
        chk({tag, ".parity_done"}, {7'b0, bus.parity_done}, {7'b0, pd});
        chk({tag, ".low_packet_valid"}, {7'b0, bus.low_packet_valid}, {7'b0, lpv});
        chk({tag, ".err"}, {7'b0, bus.err}, {7'b0, (PAR_EN ? e : 1'b0)});
    endtask

    task automatic step(input string tag, input fsm_state_e st, input logic pv, input logic ff,
                        input byte_t din, input logic extra_rst,
                        input byte_t d, input logic pd, input logic lpv, input logic e);
        drive(st, pv, ff, din, extra_rst);
        @(posedge clock);
        #1;
        expect4(tag, d, pd, lpv, e);
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++)
            step($sformatf("v%0d", i), vq[i].st, vq[i].pv, vq[i].ff, vq[i].din, 1'b0,
                 vq[i].dout, vq[i].pd, vq[i].lpv, vq[i].err);
    endtask

    initial begin
        // good packet 0C 11 22 33 / parity 0C (entries 0..7, replayed after reset)
        add(DECODE_ADDRESS,     1, 0, 8'h0C, 8'h00, 0, 0, 0);
        add(LOAD_FIRST_DATA,    1, 0, 8'h11, 8'h0C, 0, 0, 0);
        add(LOAD_DATA,          1, 0, 8'h11, 8'h11, 0, 0, 0);
        add(LOAD_DATA,          1, 0, 8'h22, 8'h22, 0, 0, 0);
        add(LOAD_DATA,          1, 0, 8'h33, 8'h33, 0, 0, 0);
        add(LOAD_DATA,          0, 0, 8'h0C, 8'h0C, 1, 1, 0);
        add(LOAD_PARITY,        0, 0, 8'h00, 8'h0C, 1, 1, 0);
        add(CHECK_PARITY_ERROR, 0, 0, 8'h00, 8'h0C, 1, 0, 0);
        // bad parity 0D: err one cycle after parity_done, held until decode
        add(DECODE_ADDRESS,     1, 0, 8'h0C, 8'h0C, 0, 0, 0);
        add(LOAD_FIRST_DATA,    1, 0, 8'h11, 8'h0C, 0, 0, 0);
        add(LOAD_DATA,          1, 0, 8'h11, 8'h11, 0, 0, 0);
        add(LOAD_DATA,          1, 0, 8'h22, 8'h22, 0, 0, 0);
        add(LOAD_DATA,          1, 0, 8'h33, 8'h33, 0, 0, 0);
        add(LOAD_DATA,          0, 0, 8'h0D, 8'h0D, 1, 1, 0);
        add(LOAD_PARITY,        0, 0, 8'h00, 8'h0D, 1, 1, 1);
        add(CHECK_PARITY_ERROR, 0, 0, 8'h00, 8'h0D, 1, 0, 1);
        add(WAIT_TILL_EMPTY,    0, 0, 8'h00, 8'h0D, 1, 0, 1);
        // FIFO full on byte 22: dout holds 11, replays 22 in LOAD_AFTER_FULL
        add(DECODE_ADDRESS,     1, 0, 8'h0C, 8'h0D, 0, 0, 0);
        add(LOAD_FIRST_DATA,    1, 0, 8'h11, 8'h0C, 0, 0, 0);
        add(LOAD_DATA,          1, 0, 8'h11, 8'h11, 0, 0, 0);
        add(LOAD_DATA,          1, 1, 8'h22, 8'h11, 0, 0, 0);
        add(FIFO_FULL_STATE,    1, 1, 8'h22, 8'h11, 0, 0, 0);
        add(LOAD_AFTER_FULL,    1, 0, 8'h22, 8'h22, 0, 0, 0);
        add(LOAD_DATA,          1, 0, 8'h33, 8'h33, 0, 0, 0);
        add(LOAD_DATA,          0, 0, 8'h0C, 8'h0C, 1, 1, 0);
        add(LOAD_PARITY,        0, 0, 8'h00, 8'h0C, 1, 1, 0);
        add(CHECK_PARITY_ERROR, 0, 0, 8'h00, 8'h0C, 1, 0, 0);
        // pkt_valid drops while full: parity_done comes from LOAD_AFTER_FULL
        add(DECODE_ADDRESS,     1, 0, 8'h0C, 8'h0C, 0, 0, 0);
        add(LOAD_FIRST_DATA,    1, 0, 8'h11, 8'h0C, 0, 0, 0);
        add(LOAD_DATA,          1, 0, 8'h11, 8'h11, 0, 0, 0);
        add(LOAD_DATA,          1, 0, 8'h22, 8'h22, 0, 0, 0);
        add(LOAD_DATA,          1, 0, 8'h33, 8'h33, 0, 0, 0);
        add(LOAD_DATA,          0, 1, 8'h0C, 8'h33, 0, 1, 0);
        add(FIFO_FULL_STATE,    0, 1, 8'h00, 8'h33, 0, 1, 0);
        add(LOAD_AFTER_FULL,    0, 0, 8'h00, 8'h0C, 1, 1, 0);
        add(LOAD_PARITY,        0, 0, 8'h00, 8'h0C, 1, 1, 0);
        add(CHECK_PARITY_ERROR, 0, 0, 8'h00, 8'h0C, 1, 0, 0);
        // header 0D, then an invalid-address decode 0F keeps 0D
        add(DECODE_ADDRESS,     1, 0, 8'h0D, 8'h0C, 0, 0, 0);
        add(LOAD_FIRST_DATA,    1, 0, 8'h55, 8'h0D, 0, 0, 0);
        add(LOAD_DATA,          1, 0, 8'h55, 8'h55, 0, 0, 0);
        add(DECODE_ADDRESS,     1, 0, 8'h0F, 8'h55, 0, 0, 0);
        add(LOAD_FIRST_DATA,    1, 0, 8'h00, 8'h0D, 0, 0, 0);
        add(LOAD_DATA,          0, 0, 8'h0D, 8'h0D, 1, 1, 0);
        add(LOAD_PARITY,        0, 0, 8'h00, 8'h0D, 1, 1, 0);
        add(CHECK_PARITY_ERROR, 0, 0, 8'h00, 8'h0D, 1, 0, 0);

        resetn = 1'b0;
        drive(WAIT_TILL_EMPTY, 1'b0, 1'b0, 8'h00, 1'b0);
        #3;
        expect4("reset", 8'h00, 0, 0, 0);
        repeat (2) @(posedge clock);
        #1;
        resetn = 1'b1;

        run_vecs(0, vq.size() - 1);

        // rst_int_reg and the low_packet_valid set in the same cycle: clear wins
        step("clr_wins", LOAD_DATA, 1'b0, 1'b0, 8'hAA, 1'b1, 8'hAA, 1, 0, 0);
        step("clr_wins_err", LOAD_PARITY, 1'b0, 1'b0, 8'h00, 1'b0, 8'hAA, 1, 0, 1);

        // asynchronous reset right after payload byte 11
        step("rst_dec", DECODE_ADDRESS, 1'b1, 1'b0, 8'h0C, 1'b0, 8'hAA, 0, 0, 0);
        step("rst_lfd", LOAD_FIRST_DATA, 1'b1, 1'b0, 8'h11, 1'b0, 8'h0C, 0, 0, 0);
        step("rst_ld", LOAD_DATA, 1'b1, 1'b0, 8'h11, 1'b0, 8'h11, 0, 0, 0);
        #2;
        resetn = 1'b0;
        #1;
        expect4("async_rst", 8'h00, 0, 0, 0);
        drive(WAIT_TILL_EMPTY, 1'b0, 1'b0, 8'h00, 1'b0);
        @(posedge clock);
        #1;
        resetn = 1'b1;
        run_vecs(0, 7);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
